mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the core's single memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU). Accepts at most one transaction at a time, forwards it to memory over a valid/ready request channel, and routes the memory response back to whichever requester owns the transaction. It sits between the fetch/LSU logic and `memory`, and replaces the direct `pc`/`waddr` wiring once fetch and data access become multi-cycle.

## Interface
Parameters:
- ADDR_WIDTH, 64, byte address width (`AddrWidth`)
- DATA_WIDTH, 64, data width (`RegWidth`)
- MASK_WIDTH, DATA_WIDTH/8, write byte-mask width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted this cycle
- ifu_addr  in  ADDR_WIDTH  fetch address
- ifu_resp_valid  out  1  fetch data valid, one-cycle pulse
- ifu_resp_data  out  DATA_WIDTH  fetch data
- lsu_req_valid  in  1  data request
- lsu_req_ready  out  1  data request accepted this cycle
- lsu_addr  in  ADDR_WIDTH  data address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_WIDTH  store data
- lsu_wmask  in  MASK_WIDTH  store byte mask
- lsu_resp_valid  out  1  load data / store ack, one-cycle pulse
- lsu_resp_data  out  DATA_WIDTH  load data (don't-care for stores)
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR/1/DATA/MASK  registered request fields
- mem_resp_valid  in  1  memory response, exactly one per accepted request (stores included)
- mem_resp_data  in  DATA_WIDTH  response data

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any req_valid, pick a winner. Assert the winner's req_ready combinationally in that cycle. Latch addr/wen/wdata/wmask (IFU: wen=0, wmask=0) and the owner, then go to ISSUE. With no valid request, stay in IDLE.
- Arbitration: a single requester always wins. On a conflict, the requester not granted last wins (round-robin). last_grant updates on every grant.
- ISSUE: mem_req_valid=1 with the latched fields, all held stable. On mem_req_ready go to WAIT, otherwise stay.
- WAIT: when mem_resp_valid arrives, the owner's resp_valid=1 and resp_data=mem_resp_data in the same cycle (combinational pass-through), and the FSM goes to IDLE. The non-owner's resp_valid stays 0.
- req_ready is 0 in ISSUE and WAIT. Requesters hold valid and fields until ready; a request that is not accepted keeps waiting.
- mem_resp_valid in IDLE or ISSUE is a protocol violation. It is ignored and no resp_valid is raised.

## Timing
- Reset values: state=IDLE, last_grant=IFU (so LSU wins the first conflict). All ready, valid and resp_valid outputs are 0, latched fields are 0.
- Reset mid-transaction: the transaction is abandoned immediately with no response pulse. A late mem_resp_valid after reset is ignored because the FSM is in IDLE.
- Minimum latency: request accepted in cycle N, mem_req_valid in N+1; with mem_req_ready=1 the FSM is in WAIT at N+2, and the earliest response pulse is at N+2.
- Throughput: at most one transaction per 3 cycles. No new grant happens in the response cycle; the next grant is at the earliest one cycle after the response.
- Back-to-back conflicts alternate LSU, IFU, LSU, … with no starvation.

## Structure
- Package `mem_arb_pkg` holds the state enum `arb_state_e` {IDLE, ISSUE, WAIT} and the owner enum `arb_owner_e` {OWNER_IFU, OWNER_LSU}. Widths come from `include/defines.v`.
- One sub-module, `rr_arb2`: a two-input round-robin pick. Inputs are the two valids and last_grant; outputs are a one-hot grant. Purely combinational; last_grant is registered in the parent.

## Test plan
- Reset, then IFU request to 0x80000000 alone with mem_req_ready=1 and the response two cycles later carrying 0x00100073 → ifu_req_ready at cycle 0, mem_req_valid at cycle 1 with addr 0x80000000 and wen=0, ifu_resp_valid pulse with 0x00100073, lsu_resp_valid stays 0.
- Simultaneous IFU and LSU requests right after reset → LSU granted first; IFU granted in the IDLE cycle after the LSU response; next conflict goes to LSU.
- LSU store to 0x80001000, wdata 0xDEADBEEF, wmask 0x0F, with mem_req_ready held low for 3 cycles → mem fields stay stable for all 3 stall cycles, one accept, lsu_resp_valid on the ack.
- Spurious mem_resp_valid in IDLE and in ISSUE → no resp_valid on either requester, state unchanged.
- Assert rst while in WAIT, then deliver mem_resp_valid → outputs 0 immediately, no response pulse, next request arbitrates with last_grant=IFU.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the memory port arbiter
package mem_arb_pkg;

  localparam int ADDR_WIDTH_DEF = 64;
  localparam int DATA_WIDTH_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IFU, LSU and memory-side signals of the shared memory port
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
);
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_WIDTH-1:0] ifu_addr;
  logic                  ifu_resp_valid;
  logic [DATA_WIDTH-1:0] ifu_resp_data;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic [ADDR_WIDTH-1:0] lsu_addr;
  logic                  lsu_wen;
  logic [DATA_WIDTH-1:0] lsu_wdata;
  logic [MASK_WIDTH-1:0] lsu_wmask;
  logic                  lsu_resp_valid;
  logic [DATA_WIDTH-1:0] lsu_resp_data;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [MASK_WIDTH-1:0] mem_wmask;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_data;

  // Arbiter view
  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  // Requester/memory environment view
  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin pick, grant[0]=IFU, grant[1]=LSU
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  arb_owner_e last_grant,
  output logic [1:0] grant
);

  // A lone requester always wins; on a conflict the one not granted last wins
  always_comb begin
    grant    = 2'b00;
    grant[0] = ifu_valid & (~lsu_valid | (last_grant == OWNER_LSU));
    grant[1] = lsu_valid & (~ifu_valid | (last_grant == OWNER_IFU));
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store requesters
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
)(
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  arb_state_e            state_q, state_d;
  arb_owner_e            last_grant_q, last_grant_d;
  arb_owner_e            owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MASK_WIDTH-1:0] wmask_q, wmask_d;
  logic [1:0]            grant;

  rr_arb2 u_rr_arb2 (
    .ifu_valid  (bus.ifu_req_valid),
    .lsu_valid  (bus.lsu_req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Request fields are driven only from flops so they stay stable through stalls
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wen   = wen_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wmask = wmask_q;

  // State register and latched transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= OWNER_IFU;
      owner_q      <= OWNER_IFU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
    end
  end

  // Next state, grant capture and response routing
  always_comb begin
    state_d            = state_q;
    last_grant_d       = last_grant_q;
    owner_d            = owner_q;
    addr_d             = addr_q;
    wen_d              = wen_q;
    wdata_d            = wdata_q;
    wmask_d            = wmask_q;
    bus.ifu_req_ready  = 1'b0;
    bus.lsu_req_ready  = 1'b0;
    bus.mem_req_valid  = 1'b0;
    bus.ifu_resp_valid = 1'b0;
    bus.ifu_resp_data  = '0;
    bus.lsu_resp_valid = 1'b0;
    bus.lsu_resp_data  = '0;

    case (state_q)
      IDLE: begin
        if (|grant) begin
          bus.ifu_req_ready = grant[0];
          bus.lsu_req_ready = grant[1];
          if (grant[1]) begin
            owner_d = OWNER_LSU;
            addr_d  = bus.lsu_addr;
            wen_d   = bus.lsu_wen;
            wdata_d = bus.lsu_wdata;
            wmask_d = bus.lsu_wmask;
          end else begin
            // Fetches are always reads with an empty mask
            owner_d = OWNER_IFU;
            addr_d  = bus.ifu_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
          end
          last_grant_d = owner_d;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        // Response passes straight through; IDLE/ISSUE responses are dropped
        if (bus.mem_resp_valid) begin
          if (owner_q == OWNER_LSU) begin
            bus.lsu_resp_valid = 1'b1;
            bus.lsu_resp_data  = bus.mem_resp_data;
          end else begin
            bus.ifu_resp_valid = 1'b1;
            bus.ifu_resp_data  = bus.mem_resp_data;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } mreq_t;

  typedef struct {
    bit          lsu;
    logic [63:0] data;
  } resp_t;

  logic  clk = 1'b0;
  logic  rst;
  int    checks = 0;
  int    errors = 0;
  mreq_t mreq_q[$];
  resp_t resp_q[$];

  mem_port_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MASK_WIDTH(8)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MASK_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic mreq_t mk(input logic [63:0] a, input logic w, input logic [63:0] d, input logic [7:0] m);
    mreq_t r;
    r.addr = a; r.wen = w; r.wdata = d; r.wmask = m;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory-side monitor: every accepted request must match the next expected one
  always @(negedge clk) begin
    if (!rst && bus.mem_req_valid && bus.mem_req_ready) begin
      if (mreq_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL mem_accept_unexpected: got addr %h expected none", bus.mem_addr);
      end else begin
        mreq_t e;
        e = mreq_q.pop_front();
        chk("mem_addr", bus.mem_addr, e.addr);
        chk("mem_wen", {63'd0, bus.mem_wen}, {63'd0, e.wen});
        chk("mem_wdata", bus.mem_wdata, e.wdata);
        chk("mem_wmask", {56'd0, bus.mem_wmask}, {56'd0, e.wmask});
      end
    end
  end

  // Response monitor: every pulse must match the next expected owner and data
  always @(negedge clk) begin
    if (bus.ifu_resp_valid || bus.lsu_resp_valid) begin
      if (bus.ifu_resp_valid && bus.lsu_resp_valid) begin
        checks++; errors++;
        $display("FAIL resp_both: got both resp_valid expected one");
      end else if (resp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp_spurious: got ifu=%0b lsu=%0b expected none", bus.ifu_resp_valid, bus.lsu_resp_valid);
      end else begin
        resp_t e;
        e = resp_q.pop_front();
        chk("resp_owner_lsu", {63'd0, bus.lsu_resp_valid}, {63'd0, e.lsu});
        chk("resp_data", bus.lsu_resp_valid ? bus.lsu_resp_data : bus.ifu_resp_data, e.data);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_readies", {62'd0, bus.ifu_req_ready, bus.lsu_req_ready}, 64'd0);
    chk("rst_mem_req_valid", {63'd0, bus.mem_req_valid}, 64'd0);
    chk("rst_resp_valid", {62'd0, bus.ifu_resp_valid, bus.lsu_resp_valid}, 64'd0);
    chk("rst_mem_fields", bus.mem_addr | bus.mem_wdata | {55'd0, bus.mem_wen, bus.mem_wmask}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One full transaction starting in IDLE; the losing requester keeps its valid
  task automatic txn(input bit iv, input bit lv, input bit exp_lsu, input mreq_t ireq, input mreq_t lreq,
                     input int stall, input bit spur, input logic [63:0] rdata);
    mreq_t w;
    resp_t r;
    bus.ifu_req_valid = iv;
    bus.ifu_addr      = ireq.addr;
    bus.lsu_req_valid = lv;
    bus.lsu_addr      = lreq.addr;
    bus.lsu_wen       = lreq.wen;
    bus.lsu_wdata     = lreq.wdata;
    bus.lsu_wmask     = lreq.wmask;
    @(negedge clk);
    chk("grant_ifu_ready", {63'd0, bus.ifu_req_ready}, {63'd0, !exp_lsu});
    chk("grant_lsu_ready", {63'd0, bus.lsu_req_ready}, {63'd0, exp_lsu});
    w = exp_lsu ? lreq : mk(ireq.addr, 1'b0, 64'd0, 8'd0);
    mreq_q.push_back(w);
    tick();
    if (exp_lsu) bus.lsu_req_valid = 1'b0;
    else         bus.ifu_req_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      bus.mem_resp_valid = spur && (i == 0);
      bus.mem_resp_data  = 64'hBAD0BAD0;
      @(negedge clk);
      chk("stall_mem_req_valid", {63'd0, bus.mem_req_valid}, 64'd1);
      chk("stall_addr", bus.mem_addr, w.addr);
      chk("stall_fields", {bus.mem_wdata[54:0], bus.mem_wen, bus.mem_wmask}, {w.wdata[54:0], w.wen, w.wmask});
      chk("stall_readies", {62'd0, bus.ifu_req_ready, bus.lsu_req_ready}, 64'd0);
      tick();
    end
    bus.mem_resp_valid = 1'b0;
    bus.mem_req_ready  = 1'b1;
    @(negedge clk);
    chk("issue_mem_req_valid", {63'd0, bus.mem_req_valid}, 64'd1);
    tick();
    bus.mem_req_ready = 1'b0;
    r.lsu = exp_lsu; r.data = rdata;
    resp_q.push_back(r);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = rdata;
    @(negedge clk);
    chk("resp_cycle_no_grant", {62'd0, bus.ifu_req_ready, bus.lsu_req_ready}, 64'd0);
    tick();
    bus.mem_resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    mreq_t none;
    none = mk(64'd0, 1'b0, 64'd0, 8'd0);
    bus.ifu_req_valid = 0; bus.ifu_addr = 0;
    bus.lsu_req_valid = 0; bus.lsu_addr = 0; bus.lsu_wen = 0; bus.lsu_wdata = 0; bus.lsu_wmask = 0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_resp_data = 0;

    // Lone fetch, zero stall
    do_reset();
    txn(1, 0, 0, mk(64'h8000_0000, 0, 0, 0), none, 0, 0, 64'h0010_0073);

    // Conflicts after reset: LSU, then IFU, then LSU
    do_reset();
    txn(1, 1, 1, mk(64'h8000_0004, 0, 0, 0), mk(64'h8000_0100, 0, 0, 0), 0, 0, 64'h1111_2222_3333_4444);
    txn(1, 1, 0, mk(64'h8000_0004, 0, 0, 0), mk(64'h8000_0108, 0, 0, 0), 0, 0, 64'h0000_0013);
    txn(1, 1, 1, mk(64'h8000_0008, 0, 0, 0), mk(64'h8000_0108, 0, 0, 0), 1, 0, 64'hCAFE_F00D);
    bus.ifu_req_valid = 0;

    // Store with three stall cycles
    txn(0, 1, 1, none, mk(64'h8000_1000, 1, 64'hDEAD_BEEF, 8'h0F), 3, 0, 64'd0);

    // Spurious responses in IDLE then in ISSUE
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 64'h5A5A;
    @(negedge clk);
    chk("idle_spur_readies", {62'd0, bus.ifu_req_ready, bus.lsu_req_ready}, 64'd0);
    chk("idle_spur_mem_req_valid", {63'd0, bus.mem_req_valid}, 64'd0);
    tick();
    bus.mem_resp_valid = 1'b0;
    txn(1, 0, 0, mk(64'h8000_0040, 0, 0, 0), none, 2, 1, 64'h0000_0297);

    // Reset while in WAIT with the response arriving at the same time
    bus.lsu_req_valid = 1; bus.lsu_addr = 64'h2000; bus.lsu_wen = 0; bus.lsu_wdata = 0; bus.lsu_wmask = 0;
    @(negedge clk);
    chk("wait_rst_grant", {62'd0, bus.ifu_req_ready, bus.lsu_req_ready}, 64'd1);
    mreq_q.push_back(mk(64'h2000, 0, 0, 0));
    tick();
    bus.lsu_req_valid = 0;
    bus.mem_req_ready = 1;
    tick();
    bus.mem_req_ready  = 0;
    bus.mem_resp_data  = 64'h55;
    bus.mem_resp_valid = 1;
    rst = 1;
    #1;
    chk("wait_rst_resp_immediate", {62'd0, bus.ifu_resp_valid, bus.lsu_resp_valid}, 64'd0);
    @(negedge clk);
    chk("wait_rst_resp", {62'd0, bus.ifu_resp_valid, bus.lsu_resp_valid}, 64'd0);
    chk("wait_rst_mem_addr", bus.mem_addr, 64'd0);
    tick();
    rst = 0;
    @(negedge clk);
    chk("late_resp_ignored", {62'd0, bus.ifu_resp_valid, bus.lsu_resp_valid}, 64'd0);
    tick();
    bus.mem_resp_valid = 0;
    txn(1, 1, 1, mk(64'h8000_0080, 0, 0, 0), mk(64'h3000, 0, 0, 0), 0, 0, 64'h7777);
    bus.ifu_req_valid = 0;

    repeat (3) tick();
    chk("mreq_q_empty", 64'(mreq_q.size()), 64'd0);
    chk("resp_q_empty", 64'(resp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
